// File: rtl/arb_client.sv
// arb_client: requester-side agent that turns a local burst command into the
// arbiter req/gnt handshake, strobing one data beat per granted cycle.
module arb_client #(
  parameter int LEN_W = 4,
  parameter int TMO   = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic             gnt,
  output logic             req,
  output logic             busy,
  output logic             valid,
  output logic [LEN_W-1:0] beat_cnt,
  output logic             done,
  output logic             err
);

  localparam int                WAIT_W    = $clog2(TMO) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TMO - 1);
  localparam logic [WAIT_W-1:0] WAIT_MAX  = '1;
  localparam logic [LEN_W-1:0]  BEAT_MAX  = '1;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    XFER,
    REL
  } state_e;

  state_e             state_q, state_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic [WAIT_W-1:0]  wait_q, wait_d;
  logic               done_q, done_d;
  logic               err_q, err_d;

  // NOTE: every signal assigned here gets a default first, so no path leaves
  // one unassigned and no latch is inferred.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    beat_d  = beat_q;
    wait_d  = wait_q;
    done_d  = 1'b0;
    err_d   = 1'b0;
    req     = (state_q == REQ) || (state_q == XFER);
    busy    = (state_q != IDLE);
    valid   = (state_q == XFER) && gnt;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          len_d   = len;
          beat_d  = '0;
          wait_d  = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        // A grant on the threshold cycle still wins over the timeout.
        if (gnt) begin
          state_d = XFER;
        end else if (wait_q == WAIT_LAST) begin
          state_d = REL;
          err_d   = 1'b1;
        end else if (wait_q != WAIT_MAX) begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      XFER: begin
        if (gnt) begin
          // Saturate so the index only returns to 0 through a new start.
          if (beat_q != BEAT_MAX) beat_d = beat_q + LEN_W'(1);
          if (beat_q == len_q) begin
            state_d = REL;
            done_d  = 1'b1;
          end
        end
      end
      REL: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      len_q   <= '0;
      beat_q  <= '0;
      wait_q  <= '0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      beat_q  <= beat_d;
      wait_q  <= wait_d;
      done_q  <= done_d;
      err_q   <= err_d;
    end
  end

  assign beat_cnt = beat_q;
  assign done     = done_q;
  assign err      = err_q;

endmodule

// File: tb/tb_arb_client.sv
// tb_arb_client: drives windows of per-cycle start/len/gnt stimulus and checks
// every output against a timeline model built from the burst rules.
module tb_arb_client;

  localparam int LEN_W = 4;
  localparam int TMO   = 16;
  localparam int W     = 100;  // cycles per stimulus window
  localparam int WS    = 30;   // starts only issued before this cycle
  localparam int GT    = 60;   // gnt forced high from here so bursts finish

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             start = 1'b0;
  logic             gnt = 1'b0;
  logic [LEN_W-1:0] len = '0;
  logic             req, busy, valid, done, err;
  logic [LEN_W-1:0] beat_cnt;

  int checks = 0;
  int errors = 0;
  int win    = 0;

  bit               g[W];
  bit               st[W];
  logic [LEN_W-1:0] lens[W];
  bit               e_req[W], e_busy[W], e_valid[W], e_done[W], e_err[W];
  bit               e_bc_chk[W];
  int               e_bc[W];

  always #5 clk = ~clk;

  arb_client #(.LEN_W(LEN_W), .TMO(TMO)) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .len      (len),
    .gnt      (gnt),
    .req      (req),
    .busy     (busy),
    .valid    (valid),
    .beat_cnt (beat_cnt),
    .done     (done),
    .err      (err)
  );

  task automatic check(input string tag, input int cyc, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s win=%0d cyc=%0d observed=%0h expected=%0h", tag, win, cyc, obs, exp);
    end
  endtask

  task automatic check_all_zero(input string tag, input int cyc);
    check({tag, ".req"}, cyc, req, 0);
    check({tag, ".busy"}, cyc, busy, 0);
    check({tag, ".valid"}, cyc, valid, 0);
    check({tag, ".done"}, cyc, done, 0);
    check({tag, ".err"}, cyc, err, 0);
    check({tag, ".beat_cnt"}, cyc, beat_cnt, 0);
  endtask

  // Stimulus modes: 0 random, 1 timeout, 2 single burst with gnt tied high,
  // 3 pre-emption pattern, 4 start every cycle, 5 grant on the last wait cycle.
  task automatic gen(input int mode, input int len_fix);
    int dens;
    bit pat[6];
    pat  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    dens = $urandom_range(1, 3);
    for (int c = 0; c < W; c++) begin
      st[c]   = 1'b0;
      lens[c] = LEN_W'($urandom_range(0, (1 << LEN_W) - 1));
      g[c]    = (c >= GT);
      case (mode)
        0: begin
          st[c] = (c < WS) && ($urandom_range(0, 3) == 0);
          if (c < GT) g[c] = ($urandom_range(0, 3) < dens);
        end
        1: st[c] = (c == 1);
        2: begin
          st[c] = (c == 1);
          g[c]  = 1'b1;
        end
        3: begin
          st[c] = (c == 1);
          if (c == 2) g[c] = 1'b1;
          if (c >= 3 && c < 9) g[c] = pat[c-3];
        end
        4: begin
          st[c] = (c < WS);
          g[c]  = 1'b1;
        end
        5: begin
          st[c] = (c == 1);
          if (c == 1 + TMO) g[c] = 1'b1;
        end
        default: ;
      endcase
      if (mode != 0) lens[c] = LEN_W'(len_fix);
    end
  endtask

  // Walks accepted commands in order: a start counts only when no burst is
  // active; each burst's grant point, beats and release cycle are then found
  // directly from the gnt timeline.
  task automatic build_model();
    int  cur, s, r, last, rel, n, c;
    bit  granted, found;
    for (int i = 0; i < W; i++) begin
      e_req[i] = 0; e_busy[i] = 0; e_valid[i] = 0; e_done[i] = 0;
      e_err[i] = 0; e_bc_chk[i] = 0; e_bc[i] = 0;
    end
    cur = 0;
    while (cur < W) begin
      found = 0;
      s = 0;
      for (int i = cur; i < W; i++) begin
        if (st[i]) begin
          s = i;
          found = 1;
          break;
        end
      end
      if (!found) break;
      granted = 0;
      r = 0;
      for (int i = s + 1; i <= s + TMO && i < W; i++) begin
        if (g[i]) begin
          r = i;
          granted = 1;
          break;
        end
      end
      if (granted) begin
        n = 0;
        last = W - 1;
        c = r + 1;
        while (n <= int'(lens[s]) && c < W) begin
          if (g[c]) begin
            e_valid[c] = 1;
            n++;
            if (n == int'(lens[s]) + 1) last = c;
          end
          c++;
        end
        rel = last + 1;
      end else begin
        rel = s + TMO + 1;
      end
      n = 0;
      for (int i = s + 1; i < rel && i < W; i++) begin
        e_req[i]    = 1;
        e_busy[i]   = 1;
        e_bc_chk[i] = 1;
        e_bc[i]     = n;
        if (e_valid[i]) n++;
      end
      if (rel < W) begin
        e_busy[rel] = 1;
        e_done[rel] = granted;
        e_err[rel]  = !granted;
      end
      cur = rel + 1;
    end
  endtask

  task automatic run_window(input int mode, input int len_fix);
    win++;
    gen(mode, len_fix);
    build_model();
    for (int c = 0; c < W; c++) begin
      @(posedge clk);
      #1;
      start = st[c];
      gnt   = g[c];
      len   = lens[c];
      @(negedge clk);
      check("req", c, req, e_req[c]);
      check("busy", c, busy, e_busy[c]);
      check("valid", c, valid, e_valid[c]);
      check("done", c, done, e_done[c]);
      check("err", c, err, e_err[c]);
      if (e_bc_chk[c]) check("beat_cnt", c, beat_cnt, e_bc[c]);
    end
    @(posedge clk);
    #1;
    start = 1'b0;
    gnt   = 1'b0;
  endtask

  initial begin
    // Reset held with start and gnt high: everything stays at zero.
    rst   = 1'b0;
    start = 1'b1;
    gnt   = 1'b1;
    len   = 4'd5;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      check_all_zero("reset", c);
    end
    @(posedge clk);
    #1;
    rst   = 1'b1;
    start = 1'b0;
    gnt   = 1'b0;
    @(negedge clk);
    check_all_zero("post_reset", 0);

    run_window(2, 3);   // single burst, len=3, gnt tied high
    run_window(3, 3);   // pre-emption gaps during XFER
    run_window(1, 0);   // timeout with no grant
    run_window(5, 2);   // grant on the threshold cycle beats the timeout
    run_window(4, 1);   // start every cycle: ignored while busy, back-to-back
    run_window(2, 15);  // longest burst

    // Mid-burst reset after beat 3 of an 8-beat burst.
    win++;
    @(posedge clk);
    #1;
    start = 1'b1;
    len   = 4'd7;
    gnt   = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(negedge clk);
    check("mid.req_in_req", 0, req, 1);
    check("mid.valid_in_req", 0, valid, 0);
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      @(negedge clk);
      check("mid.valid", i, valid, 1);
      check("mid.beat_cnt", i, beat_cnt, i);
    end
    #2;
    rst = 1'b0;
    #1;
    check_all_zero("mid.async", 0);
    @(posedge clk);
    @(negedge clk);
    check_all_zero("mid.held", 1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    gnt = 1'b0;
    run_window(2, 7);   // full 8-beat burst from beat 0 after reset

    for (int k = 0; k < 10; k++) run_window(0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
